// File: rtl/reg_sb_pkg.sv
// Shared types and helpers for the register write scoreboard.
// Maps register-file select encodings onto an 11-slot register id space.
package reg_sb_pkg;

    localparam logic [1:0] SPEC_GEN = 2'b00;
    localparam logic [1:0] SPEC_SP  = 2'b01;
    localparam logic [1:0] SPEC_IH  = 2'b10;
    localparam logic [1:0] SPEC_T   = 2'b11;

    localparam logic [3:0] ID_SP = 4'd8;
    localparam logic [3:0] ID_IH = 4'd9;
    localparam logic [3:0] ID_T  = 4'd10;
    localparam int NUM_IDS = 11;

    typedef struct packed {
        logic       wr;
        logic [3:0] id;
    } sb_entry_t;

    function automatic logic [3:0] reg_id(
        input logic [1:0] spec,
        input logic [2:0] idx
    );
        logic [3:0] id;
        case (spec)
            SPEC_SP: id = ID_SP;
            SPEC_IH: id = ID_IH;
            SPEC_T:  id = ID_T;
            default: id = {1'b0, idx};
        endcase
        return id;
    endfunction

    function automatic logic [1:0] id_spec(input logic [3:0] id);
        logic [1:0] s;
        case (id)
            ID_SP:   s = SPEC_SP;
            ID_IH:   s = SPEC_IH;
            ID_T:    s = SPEC_T;
            default: s = SPEC_GEN;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] id_idx(input logic [3:0] id);
        return id[3] ? 3'd0 : id[2:0];
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular buffer of {wr, id} entries with push, pop and tail flush.
// Ports: push/pop/flush count in; head entry, occupancy and tail-flush view out.
module sb_fifo
    import reg_sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  sb_entry_t        push_data_i,
    input  logic             pop_i,
    input  logic [CNT_W-1:0] flush_num_i,
    output sb_entry_t        head_o,
    output logic [CNT_W-1:0] occupancy_o,
    output sb_entry_t        flush_ent_o [DEPTH],
    output logic             flush_en_o  [DEPTH]
);

    localparam int AW = CNT_W - 1;

    sb_entry_t        mem_q [DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] slot;

    assign occupancy_o = wr_ptr_q - rd_ptr_q;
    assign head_o      = mem_q[rd_ptr_q[AW-1:0]];

    // Slot i of the flush view is the i-th youngest entry; flush_num_i
    // is already clamped so it never reaches the entry being popped.
    always_comb begin
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = wr_ptr_q - CNT_W'(i) - CNT_W'(1);
            flush_ent_o[i] = mem_q[slot[AW-1:0]];
            flush_en_o[i]  = CNT_W'(i) < flush_num_i;
        end
    end

    assign rd_ptr_d = rd_ptr_q + CNT_W'(pop_i);
    assign wr_ptr_d = wr_ptr_q + CNT_W'(push_i) - flush_num_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order write scoreboard: tracks in-flight register writes, stalls issue on hazards.
// Ports: issue/src/retire/flush in; stall, full, empty, occupancy, head_*, retire_err out.
module reg_scoreboard
    import reg_sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             issue_valid,
    input  logic             issue_wr,
    input  logic [1:0]       issue_spec,
    input  logic [2:0]       issue_idx,
    input  logic             src1_used,
    input  logic [1:0]       src1_spec,
    input  logic [2:0]       src1_idx,
    input  logic             src2_used,
    input  logic [2:0]       src2_idx,
    input  logic             retire_valid,
    input  logic             flush_valid,
    input  logic [CNT_W-1:0] flush_num,
    output logic             stall,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] occupancy,
    output logic             head_wr,
    output logic [1:0]       head_spec,
    output logic [2:0]       head_idx,
    output logic             retire_err
);

    logic [CNT_W-1:0] pend_q [NUM_IDS];
    logic [CNT_W-1:0] pend_d [NUM_IDS];
    logic             err_q;

    sb_entry_t        head;
    sb_entry_t        push_data;
    sb_entry_t        fl_ent [DEPTH];
    logic             fl_en  [DEPTH];
    logic             push, pop, hazard, flush_over;
    logic [3:0]       src1_id;
    logic [CNT_W-1:0] remaining, flush_n, cnt;

    sb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_num_i (flush_n),
        .head_o      (head),
        .occupancy_o (occupancy),
        .flush_ent_o (fl_ent),
        .flush_en_o  (fl_en)
    );

    assign full  = occupancy == CNT_W'(DEPTH);
    assign empty = occupancy == '0;

    assign src1_id = reg_id(src1_spec, src1_idx);
    assign hazard  = (src1_used && pend_q[src1_id] != '0)
                   | (src2_used && pend_q[{1'b0, src2_idx}] != '0);
    assign stall   = hazard | full | flush_valid;

    assign push      = issue_valid & ~stall;
    assign push_data = '{wr: issue_wr, id: reg_id(issue_spec, issue_idx)};
    assign pop       = retire_valid & ~empty;

    // Retire happens before flush, so the flush sees the post-pop count.
    assign remaining  = occupancy - CNT_W'(pop);
    assign flush_over = flush_num > remaining;
    assign flush_n    = !flush_valid ? '0
                      : flush_over   ? remaining : flush_num;

    always_comb begin
        cnt = '0;
        for (int j = 0; j < NUM_IDS; j++) begin
            cnt = pend_q[j];
            if (push && issue_wr && push_data.id == 4'(j))
                cnt = cnt + CNT_W'(1);
            if (pop && head.wr && head.id == 4'(j))
                cnt = cnt - CNT_W'(1);
            for (int i = 0; i < DEPTH; i++)
                if (fl_en[i] && fl_ent[i].wr && fl_ent[i].id == 4'(j))
                    cnt = cnt - CNT_W'(1);
            pend_d[j] = cnt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
            for (int j = 0; j < NUM_IDS; j++) pend_q[j] <= '0;
        end else begin
            err_q  <= err_q | (retire_valid & empty)
                    | (flush_valid & flush_over);
            pend_q <= pend_d;
        end
    end

    assign head_wr    = ~empty & head.wr;
    assign head_spec  = empty ? 2'b00 : id_spec(head.id);
    assign head_idx   = empty ? 3'd0 : id_idx(head.id);
    assign retire_err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: vector table plus multi-cycle sequences.
// Drives on negedge, samples 2ns later, well away from the rising edge.
module tb_reg_scoreboard;

    logic       CLK = 1'b0;
    logic       RST;
    logic       issue_valid, issue_wr;
    logic [1:0] issue_spec;
    logic [2:0] issue_idx;
    logic       src1_used;
    logic [1:0] src1_spec;
    logic [2:0] src1_idx;
    logic       src2_used;
    logic [2:0] src2_idx;
    logic       retire_valid, flush_valid;
    logic [2:0] flush_num;
    logic       stall, full, empty;
    logic [2:0] occupancy;
    logic       head_wr;
    logic [1:0] head_spec;
    logic [2:0] head_idx;
    logic       retire_err;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    reg_scoreboard dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_spec(issue_spec), .issue_idx(issue_idx),
        .src1_used(src1_used), .src1_spec(src1_spec), .src1_idx(src1_idx),
        .src2_used(src2_used), .src2_idx(src2_idx),
        .retire_valid(retire_valid), .flush_valid(flush_valid),
        .flush_num(flush_num),
        .stall(stall), .full(full), .empty(empty), .occupancy(occupancy),
        .head_wr(head_wr), .head_spec(head_spec), .head_idx(head_idx),
        .retire_err(retire_err)
    );

    typedef struct packed {
        logic       iv, iw;
        logic [1:0] ispec;
        logic [2:0] iidx;
        logic       s1u;
        logic [1:0] s1spec;
        logic [2:0] s1idx;
        logic       s2u;
        logic [2:0] s2idx;
        logic       rv, fv;
        logic [2:0] fn;
        logic       e_stall, e_full, e_empty;
        logic [2:0] e_occ;
        logic       e_hwr;
        logic [1:0] e_hspec;
        logic [2:0] e_hidx;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(
        input logic iv, iw, input logic [1:0] ispec, input logic [2:0] iidx,
        input logic s1u, input logic [1:0] s1spec, input logic [2:0] s1idx,
        input logic s2u, input logic [2:0] s2idx,
        input logic rv, fv, input logic [2:0] fn,
        input logic st, fu, em, input logic [2:0] oc,
        input logic hw, input logic [1:0] hs, input logic [2:0] hi,
        input logic er
    );
        vec_t v;
        v = '{iv, iw, ispec, iidx, s1u, s1spec, s1idx, s2u, s2idx,
              rv, fv, fn, st, fu, em, oc, hw, hs, hi, er};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(
        input string tag, input logic st, fu, em, input logic [2:0] oc,
        input logic hw, input logic [1:0] hs, input logic [2:0] hi,
        input logic er
    );
        chk({tag, ".stall"}, int'(stall), int'(st));
        chk({tag, ".full"}, int'(full), int'(fu));
        chk({tag, ".empty"}, int'(empty), int'(em));
        chk({tag, ".occ"}, int'(occupancy), int'(oc));
        chk({tag, ".head_wr"}, int'(head_wr), int'(hw));
        chk({tag, ".head_spec"}, int'(head_spec), int'(hs));
        chk({tag, ".head_idx"}, int'(head_idx), int'(hi));
        chk({tag, ".err"}, int'(retire_err), int'(er));
        for (int k = 0; k < 11; k++) begin
            tests++;
            if (dut.pend_q[k] > 3'd4) begin
                fails++;
                $display("FAIL %s.pend[%0d]: got %0d expected <=4",
                         tag, k, dut.pend_q[k]);
            end
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_wr = 0; issue_spec = 0; issue_idx = 0;
        src1_used = 0; src1_spec = 0; src1_idx = 0;
        src2_used = 0; src2_idx = 0;
        retire_valid = 0; flush_valid = 0; flush_num = 0;
    endtask

    task automatic issue(input logic [1:0] sp, input logic [2:0] ix);
        idle();
        issue_valid = 1; issue_wr = 1; issue_spec = sp; issue_idx = ix;
        @(negedge CLK);
    endtask

    initial begin
        idle();
        RST = 0;
        // iv iw sp ix | s1u sp ix | s2u ix | rv fv fn || st fu em oc hw hs hi er
        add(1,1,0,3, 0,0,0, 0,0, 0,0,0, 0,0,1,0,0,0,0,0);
        add(0,0,0,0, 1,0,3, 0,0, 0,0,0, 1,0,0,1,1,0,3,0);
        add(0,0,0,0, 1,0,3, 0,0, 1,0,0, 1,0,0,1,1,0,3,0);
        add(0,0,0,0, 1,0,3, 0,0, 0,0,0, 0,0,1,0,0,0,0,0);
        add(1,1,1,0, 0,0,0, 0,0, 0,0,0, 0,0,1,0,0,0,0,0);
        add(0,0,0,0, 1,1,0, 1,0, 0,0,0, 1,0,0,1,1,1,0,0);
        add(0,0,0,0, 1,0,0, 1,0, 0,0,0, 0,0,0,1,1,1,0,0);
        add(0,0,0,0, 0,0,0, 0,0, 1,0,0, 0,0,0,1,1,1,0,0);
        add(0,0,0,0, 1,1,0, 0,0, 0,0,0, 0,0,1,0,0,0,0,0);
        add(1,1,0,1, 0,0,0, 0,0, 0,0,0, 0,0,1,0,0,0,0,0);
        add(1,1,0,2, 0,0,0, 0,0, 0,0,0, 0,0,0,1,1,0,1,0);
        add(1,1,0,4, 0,0,0, 0,0, 0,0,0, 0,0,0,2,1,0,1,0);
        add(1,1,0,5, 0,0,0, 0,0, 0,0,0, 0,0,0,3,1,0,1,0);
        add(1,1,0,7, 0,0,0, 0,0, 1,0,0, 1,1,0,4,1,0,1,0);
        add(0,0,0,0, 1,0,7, 0,0, 0,0,0, 0,0,0,3,1,0,2,0);
        add(0,0,0,0, 0,0,0, 0,0, 1,0,0, 0,0,0,3,1,0,2,0);
        add(0,0,0,0, 0,0,0, 0,0, 1,0,0, 0,0,0,2,1,0,4,0);
        add(0,0,0,0, 0,0,0, 0,0, 1,0,0, 0,0,0,1,1,0,5,0);
        add(0,0,0,0, 1,0,5, 0,0, 0,0,0, 0,0,1,0,0,0,0,0);
        add(1,1,0,6, 0,0,0, 0,0, 0,0,0, 0,0,1,0,0,0,0,0);
        add(1,1,0,6, 0,0,0, 0,0, 0,0,0, 0,0,0,1,1,0,6,0);
        add(0,0,0,0, 0,0,0, 0,0, 1,0,0, 0,0,0,2,1,0,6,0);
        add(0,0,0,0, 1,0,6, 0,0, 0,0,0, 1,0,0,1,1,0,6,0);
        add(0,0,0,0, 1,0,6, 0,0, 1,0,0, 1,0,0,1,1,0,6,0);
        add(0,0,0,0, 1,0,6, 0,0, 0,0,0, 0,0,1,0,0,0,0,0);
        add(1,1,0,6, 0,0,0, 0,0, 0,0,0, 0,0,1,0,0,0,0,0);
        add(1,1,0,6, 0,0,0, 0,0, 1,0,0, 0,0,0,1,1,0,6,0);
        add(0,0,0,0, 1,0,6, 0,0, 1,0,0, 1,0,0,1,1,0,6,0);
        add(0,0,0,0, 0,0,0, 1,6, 0,0,0, 0,0,1,0,0,0,0,0);
        add(1,1,0,1, 0,0,0, 0,0, 0,0,0, 0,0,1,0,0,0,0,0);
        add(1,1,3,0, 0,0,0, 0,0, 0,0,0, 0,0,0,1,1,0,1,0);
        add(1,1,0,2, 0,0,0, 0,0, 0,0,0, 0,0,0,2,1,0,1,0);
        add(1,1,0,7, 0,0,0, 0,0, 0,1,2, 1,0,0,3,1,0,1,0);
        add(0,0,0,0, 1,3,0, 1,2, 0,0,0, 0,0,0,1,1,0,1,0);
        add(0,0,0,0, 0,0,0, 1,1, 0,0,0, 1,0,0,1,1,0,1,0);
        add(0,0,0,0, 0,0,0, 0,0, 0,1,3, 1,0,0,1,1,0,1,0);
        add(0,0,0,0, 0,0,0, 1,1, 0,0,0, 0,0,1,0,0,0,0,1);
        add(0,0,0,0, 0,0,0, 0,0, 1,0,0, 0,0,1,0,0,0,0,1);
        add(0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,1,0,0,0,0,1);

        repeat (2) @(negedge CLK);
        #2 chk_all("reset", 0,0,1,0,0,0,0,0);
        RST = 1;
        @(negedge CLK);

        foreach (tbl[n]) begin
            vec_t v;
            v = tbl[n];
            issue_valid = v.iv; issue_wr = v.iw;
            issue_spec = v.ispec; issue_idx = v.iidx;
            src1_used = v.s1u; src1_spec = v.s1spec; src1_idx = v.s1idx;
            src2_used = v.s2u; src2_idx = v.s2idx;
            retire_valid = v.rv; flush_valid = v.fv; flush_num = v.fn;
            #2 chk_all($sformatf("vec%0d", n), v.e_stall, v.e_full,
                       v.e_empty, v.e_occ, v.e_hwr, v.e_hspec,
                       v.e_hidx, v.e_err);
            @(negedge CLK);
        end

        // async reset in the middle of traffic
        issue(0, 1);
        issue(0, 2);
        idle();
        src1_used = 1; src1_idx = 1;
        #2 chk_all("pre_rst", 1,0,0,2,1,0,1,1);
        #1 RST = 0;
        #1 chk_all("mid_rst", 0,0,1,0,0,0,0,0);
        @(negedge CLK);
        RST = 1;
        #2 chk("post_rst.stall", int'(stall), 0);
        @(negedge CLK);

        // retire and flush in one cycle: pop R1, then drop R3 and R2
        issue(0, 1);
        issue(0, 2);
        issue(0, 3);
        idle();
        retire_valid = 1; flush_valid = 1; flush_num = 2;
        #2 chk_all("rf_pre", 1,0,0,3,1,0,1,0);
        @(negedge CLK);
        idle();
        src1_used = 1; src1_idx = 3; src2_used = 1; src2_idx = 2;
        #2 chk_all("rf_post", 0,0,1,0,0,0,0,0);
        src1_idx = 1; src2_used = 0;
        #1 chk("rf_r1.stall", int'(stall), 0);
        @(negedge CLK);

        // retire while empty sets the sticky error
        idle();
        retire_valid = 1;
        @(negedge CLK);
        idle();
        #2 chk_all("err_set", 0,0,1,0,0,0,0,1);
        @(negedge CLK);
        #2 chk("err_sticky", int'(retire_err), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
